// File: rtl/hilo_muldiv_if.sv
// EX-stage multiply/divide port bundle between the pipeline and hilo_muldiv.
// Latency: none (wires only).
// Backpressure: stall from the unit holds the pipeline; start/operands are held while stall is high.
// Ports: start, alucontrol, a, b, flush (pipeline -> unit); stall, hi, lo (unit -> pipeline).
interface hilo_muldiv_if;
    logic        start;
    logic [7:0]  alucontrol;
    logic [31:0] a;
    logic [31:0] b;
    logic        flush;
    logic        stall;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, alucontrol, a, b, flush,
        input  stall, hi, lo
    );

    modport slave (
        input  start, alucontrol, a, b, flush,
        output stall, hi, lo
    );
endinterface

// File: rtl/hilo_muldiv.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit plus MTHI/MTLO, owning the HI/LO register pair.
// Latency: mul 2 stall cycles, div 33 stall cycles, MTHI/MTLO 1 cycle with no stall.
// Backpressure: combinational stall holds the pipeline while an operation is in flight; drops in DONE.
// Ports: clk, resetn (async active-low), bus (slave side of hilo_muldiv_if).
module hilo_muldiv (
    input  logic         clk,
    input  logic         resetn,
    hilo_muldiv_if.slave bus
);
    localparam logic [7:0] EXE_MULT_OP  = 8'h18;
    localparam logic [7:0] EXE_MULTU_OP = 8'h19;
    localparam logic [7:0] EXE_DIV_OP   = 8'h1A;
    localparam logic [7:0] EXE_DIVU_OP  = 8'h1B;
    localparam logic [7:0] EXE_MTHI_OP  = 8'h11;
    localparam logic [7:0] EXE_MTLO_OP  = 8'h13;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t      state, state_nxt;
    logic        stall;
    logic [31:0] hi_q, lo_q;
    logic [31:0] op_a, op_b;   // mul: raw operands; div: raw dividend / |divisor|
    logic        mul_signed;
    logic        q_neg, r_neg;
    logic [5:0]  cnt;
    logic [63:0] rem;          // {partial remainder, dividend/quotient bits}

    // Operation decode; only acted on in IDLE with no flush.
    logic accept, is_mul, is_div, is_mthi, is_mtlo, div_signed;
    assign accept     = (state == S_IDLE) && bus.start && !bus.flush;
    assign is_mul     = (bus.alucontrol == EXE_MULT_OP) || (bus.alucontrol == EXE_MULTU_OP);
    assign is_div     = (bus.alucontrol == EXE_DIV_OP)  || (bus.alucontrol == EXE_DIVU_OP);
    assign is_mthi    = (bus.alucontrol == EXE_MTHI_OP);
    assign is_mtlo    = (bus.alucontrol == EXE_MTLO_OP);
    assign div_signed = (bus.alucontrol == EXE_DIV_OP);

    // Multiply: sign-extend to 64 bits; the low 64 bits of the product are then
    // correct for both signed and unsigned operands.
    logic [63:0] ext_a, ext_b, product;
    assign ext_a   = {{32{mul_signed & op_a[31]}}, op_a};
    assign ext_b   = {{32{mul_signed & op_b[31]}}, op_b};
    assign product = ext_a * ext_b;

    // Restoring divide step. The shifted partial remainder can need 33 bits
    // when the divisor exceeds 2^31, so the compare takes rem[63:31].
    logic [32:0] diff;
    logic [63:0] rem_step;
    assign diff     = rem[63:31] - {1'b0, op_b};
    assign rem_step = diff[32] ? {rem[62:0], 1'b0}
                               : {diff[31:0], rem[30:0], 1'b1};

    logic [31:0] q_raw, r_raw, q_fin, r_fin;
    logic        div_zero;
    assign q_raw    = rem_step[31:0];
    assign r_raw    = rem_step[63:32];
    assign div_zero = (op_b == 32'd0);
    // Divide-by-zero returns all-ones quotient and the untouched dividend.
    assign q_fin    = div_zero ? 32'hFFFF_FFFF : (q_neg ? -q_raw : q_raw);
    assign r_fin    = div_zero ? op_a          : (r_neg ? -r_raw : r_raw);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= S_IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        stall     = 1'b0;
        case (state)
            S_IDLE: begin
                if (accept && is_mul) begin
                    state_nxt = S_MUL;
                    stall     = 1'b1;
                end else if (accept && is_div) begin
                    state_nxt = S_DIV;
                    stall     = 1'b1;
                end
            end
            S_MUL: begin
                stall     = 1'b1;
                state_nxt = bus.flush ? S_IDLE : S_DONE;
            end
            S_DIV: begin
                stall = 1'b1;
                if (bus.flush)          state_nxt = S_IDLE;
                else if (cnt == 6'd31)  state_nxt = S_DONE;
            end
            // Same instruction is still on start here; never re-accept it.
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hi_q       <= 32'd0;
            lo_q       <= 32'd0;
            op_a       <= 32'd0;
            op_b       <= 32'd0;
            mul_signed <= 1'b0;
            q_neg      <= 1'b0;
            r_neg      <= 1'b0;
            cnt        <= 6'd0;
            rem        <= 64'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        if (is_mul) begin
                            op_a       <= bus.a;
                            op_b       <= bus.b;
                            mul_signed <= (bus.alucontrol == EXE_MULT_OP);
                        end else if (is_div) begin
                            op_a  <= bus.a;
                            op_b  <= (div_signed && bus.b[31]) ? -bus.b : bus.b;
                            rem   <= {32'd0, (div_signed && bus.a[31]) ? -bus.a : bus.a};
                            q_neg <= div_signed & (bus.a[31] ^ bus.b[31]);
                            r_neg <= div_signed & bus.a[31];
                            cnt   <= 6'd0;
                        end else if (is_mthi) begin
                            hi_q <= bus.a;
                        end else if (is_mtlo) begin
                            lo_q <= bus.a;
                        end
                    end
                end
                S_MUL: begin
                    if (!bus.flush) begin
                        hi_q <= product[63:32];
                        lo_q <= product[31:0];
                    end
                end
                S_DIV: begin
                    if (!bus.flush) begin
                        rem <= rem_step;
                        cnt <= cnt + 6'd1;
                        if (cnt == 6'd31) begin
                            hi_q <= r_fin;
                            lo_q <= q_fin;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.stall = stall;
    assign bus.hi    = hi_q;
    assign bus.lo    = lo_q;
endmodule

// File: doc/hilo_muldiv.md
# hilo_muldiv

Multi-cycle multiply/divide unit with the architectural HI/LO register pair, sitting in the EX stage beside the ALU. Executes the MULT, MULTU, DIV, DIVU, MTHI and MTLO operation codes produced by the instruction-to-alucontrol decoder. Holds the pipeline with a stall output while an operation is in flight. HI/LO feed MFHI/MFLO selection downstream.

## Interface
- No parameters; datapath fixed at 32 bits; alucontrol codes are the `defines.vh` macros: `EXE_MULT_OP`=8'h18, `EXE_MULTU_OP`=8'h19, `EXE_DIV_OP`=8'h1A, `EXE_DIVU_OP`=8'h1B, `EXE_MTHI_OP`=8'h11, `EXE_MTLO_OP`=8'h13.
- clk  in  1  single clock; all state updates on rising edge
- resetn  in  1  asynchronous, active-low reset
- start  in  1  EX-stage instruction valid; held high by the pipeline while stall is high
- alucontrol  in  8  decoded operation; codes other than the six above are ignored
- a  in  32  rs operand (dividend / multiplicand / MTHI-MTLO source)
- b  in  32  rt operand (divisor / multiplier)
- flush  in  1  abort current operation (exception/branch flush), synchronous
- stall  out  1  hold EX and earlier stages
- hi  out  32  HI register
- lo  out  32  LO register

## Operation
- State machine: IDLE, MUL, DIV, DONE. Reset: state=IDLE, hi=0, lo=0, stall=0, counter=0.
- IDLE, flush=0, start=1:
  - MULT/MULTU: latch a, b and signedness; -> MUL; stall=1 (combinational in this cycle).
  - DIV/DIVU: latch |a|, |b| (signed) or a, b (unsigned), quotient sign = a[31]^b[31], remainder sign = a[31] (signed only); clear 6-bit counter; -> DIV; stall=1.
  - MTHI: hi<=a at edge; MTLO: lo<=a at edge; stay IDLE; stall=0.
  - Any other code: no action, stall=0.
- MUL: 64-bit product (signed for MULT, unsigned for MULTU) written {hi,lo}<=product at edge; -> DONE; stall=1.
- DIV: restoring radix-2, one quotient bit per cycle, 32 iterations; 64-bit partial remainder shifted left 1, upper 33-bit subtract of divisor, keep if non-negative. At end of iteration 32: apply sign fix (negate quotient if quotient sign, negate remainder if remainder sign), lo<=quotient, hi<=remainder; -> DONE; stall=1 throughout.
- DONE: stall=0 so the pipeline advances; start seen in DONE is ignored (same instruction still present); -> IDLE.
- Divisor zero: completes in normal time; lo=32'hFFFF_FFFF, hi=a unmodified, no sign fix, no exception.
- Signed overflow 0x8000_0000 / 0xFFFF_FFFF: lo=32'h8000_0000, hi=0.
- flush=1 in MUL or DIV: -> IDLE at next edge, hi/lo not written, stall drops next cycle. flush=1 in IDLE: start ignored, no MTHI/MTLO write. flush in DONE: result already committed; -> IDLE.
- resetn low at any point: immediate return to reset values, in-flight result discarded.

## Timing
- Cycle numbering from the IDLE cycle with start=1 (cycle 0).
- MULT/MULTU: stall high cycles 0-1; hi/lo valid from cycle 2; stall low cycle 2 (DONE).
- DIV/DIVU: stall high cycles 0-32; hi/lo valid from cycle 33; stall low cycle 33 (DONE).
- MTHI/MTLO: single cycle, no stall; hi/lo visible cycle 1.
- Back-to-back: new operation accepted no earlier than cycle after DONE (IDLE).
- stall is combinational from state, start, alucontrol, flush; hi/lo are registered outputs.

## Test plan
- Reset mid-DIV (resetn low at cycle 10) -> hi=0, lo=0, stall=0 immediately; later DIVU 100/7 -> lo=14, hi=2 at cycle 33.
- MULT a=0xFFFF_FFFE(-2), b=3 -> stall high 2 cycles, {hi,lo}=0xFFFF_FFFF_FFFF_FFFA; MULTU same -> hi=0x0000_0002, lo=0xFFFF_FFFA.
- DIV a=-7 (0xFFFF_FFF9), b=2 -> lo=0xFFFF_FFFD(-3), hi=0xFFFF_FFFF(-1), stall exactly 33 cycles then one DONE cycle with stall=0.
- DIV 0x8000_0000 / 0xFFFF_FFFF -> lo=0x8000_0000, hi=0; DIVU 5/0 -> lo=0xFFFF_FFFF, hi=5.
- DIV in flight, flush at cycle 20 -> IDLE next edge, hi/lo keep prior values, stall=0 next cycle.
- MTHI a=0x1234_5678 then MTLO a=0x9ABC_DEF0 on consecutive cycles -> no stall, hi/lo updated one cycle after each; MTHI with flush=1 -> hi unchanged.
